face_frame_streamer: RTL and testbench

- Display-side consumer of the pet FSM's face code and five stat values; produces the `done` strobe the FSM advances its face sequence on.
- Each frame: latches face and stats, streams a 16x16 face sprite from a synchronous sprite ROM, then 25 stat-bar pixels, over a valid/ready pixel port to the panel driver.
- Pulses `done`, waits a programmable gap, then repeats.

---
 rtl/pet_pkg.sv | 41 ++++
 rtl/face_frame_streamer_if.sv | 29 ++
 rtl/stat_bar_pixel.sv | 27 ++
 rtl/face_frame_streamer.sv | 194 +++++++++++++++++++
 tb/tb_face_frame_streamer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pet_pkg
// Description : Shared face codes, stat limits and streamer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pet_pkg;

    localparam logic [3:0] FACE_BLANK   = 4'h0;
    localparam logic [3:0] FACE_INIT    = 4'h1;
    localparam logic [3:0] FACE_FEED    = 4'h2;
    localparam logic [3:0] FACE_HEAL    = 4'h3;
    localparam logic [3:0] FACE_SLEEP   = 4'h4;
    localparam logic [3:0] FACE_PLAY    = 4'h5;
    localparam logic [3:0] FACE_WAIT    = 4'h6;
    localparam logic [3:0] FACE_TEST    = 4'h7;
    localparam logic [3:0] FACE_HAPPY   = 4'h8;
    localparam logic [3:0] FACE_NEUTRAL = 4'h9;
    localparam logic [3:0] FACE_SAD     = 4'hA;
    localparam logic [3:0] FACE_DEAD    = 4'hB;
    localparam logic [3:0] FACE_DEFAULT = 4'hC;

    localparam int STAT_MAX = 5;

    typedef enum logic [2:0] {
        ST_LATCH = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_BAR   = 3'd4,
        ST_DONE  = 3'd5,
        ST_GAP   = 3'd6
    } stream_state_t;

    // Unassigned codes share the blank sprite slot.
    function automatic logic [3:0] face_slot(input logic [3:0] code);
        return ((code == FACE_BLANK) || (code > FACE_DEFAULT)) ? FACE_BLANK : code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/face_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : face_frame_streamer_if
// Description : Valid/ready RGB565 pixel stream towards the panel driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface face_frame_streamer_if;

    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_first;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_first,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_first,
        output pix_ready
    );

endinterface
`default_nettype wire

// File: rtl/stat_bar_pixel.sv
`default_nettype none
// ============================================================================
// Module      : stat_bar_pixel
// Description : Colour of one stat-bar segment from a (clamped) stat value.
// Revision    : 1.0 - initial release
// ============================================================================
module stat_bar_pixel
    import pet_pkg::*;
#(
    parameter int BAR_MAX = STAT_MAX
)(
    input  wire  [2:0]  i_stat,
    input  wire  [2:0]  i_seg,
    input  wire  [15:0] i_bar_on,
    input  wire  [15:0] i_bar_off,
    output logic [15:0] o_colour
);

    logic [2:0] w_stat_clamped;

    always_comb begin
        w_stat_clamped = (i_stat > 3'(BAR_MAX)) ? 3'(BAR_MAX) : i_stat;
        o_colour       = (i_seg < w_stat_clamped) ? i_bar_on : i_bar_off;
    end

endmodule
`default_nettype wire

// File: rtl/face_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : face_frame_streamer
// Description : Streams a face sprite plus five stat bars per frame, then
//               pulses done and idles for a programmable gap.
// Revision    : 1.0 - initial release
// ============================================================================
module face_frame_streamer
    import pet_pkg::*;
#(
    parameter int          SPR_W     = 16,
    parameter int          SPR_H     = 16,
    parameter int          BAR_MAX   = 5,
    parameter logic [15:0] BAR_ON    = 16'h07E0,
    parameter logic [15:0] BAR_OFF   = 16'h0000,
    parameter int          FRAME_GAP = 1000000
)(
    input  wire                                 clk,
    input  wire                                 rst,
    input  wire  [3:0]                          face,
    input  wire  [2:0]                          food_val,
    input  wire  [2:0]                          sleep_val,
    input  wire  [2:0]                          fun_val,
    input  wire  [2:0]                          happy_val,
    input  wire  [2:0]                          health_val,
    output logic [$clog2(SPR_W*SPR_H)+3:0]      rom_addr,
    input  wire  [15:0]                         rom_data,
    face_frame_streamer_if.master               pix,
    output logic                                done,
    output logic                                busy
);

    localparam int c_PIX_W    = $clog2(SPR_W*SPR_H);
    localparam int c_NUM_BARS = 5;
    localparam int c_GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [c_PIX_W-1:0] c_LAST_PIX = c_PIX_W'(SPR_W*SPR_H - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(FRAME_GAP - 1);
    localparam logic [2:0]         c_LAST_SEG = 3'(BAR_MAX - 1);
    localparam logic [2:0]         c_LAST_BAR = 3'(c_NUM_BARS - 1);

    stream_state_t                  r_state;
    logic [3:0]                     r_face_l;
    logic [c_NUM_BARS-1:0][2:0]     r_stat;
    logic [c_PIX_W-1:0]             r_pix_idx;
    logic [2:0]                     r_bar_b;
    logic [2:0]                     r_bar_s;
    logic [c_GAP_W-1:0]             r_gap_cnt;
    logic [c_PIX_W+3:0]             r_rom_addr;
    logic [15:0]                    r_pix_data;
    logic                           r_pix_valid;
    logic                           r_pix_first;
    logic                           r_done;
    logic                           r_busy;

    logic                           w_hs;
    logic [3:0]                     w_slot;
    logic [c_PIX_W-1:0]             w_pix_idx_nxt;
    logic [2:0]                     w_next_b;
    logic [2:0]                     w_next_s;
    logic [2:0]                     w_bar_stat;
    logic                           w_bar_last;
    logic [15:0]                    w_bar_colour;

    function automatic logic [2:0] clamp_stat(input logic [2:0] v);
        return (v > 3'(BAR_MAX)) ? 3'(BAR_MAX) : v;
    endfunction

    assign w_hs          = r_pix_valid & pix.pix_ready;
    assign w_slot        = face_slot(face);
    assign w_pix_idx_nxt = r_pix_idx + 1'b1;
    assign w_bar_last    = (r_bar_b == c_LAST_BAR) && (r_bar_s == c_LAST_SEG);

    // Segment to be shown after the current beat; (0,0) when leaving the sprite.
    always_comb begin
        w_next_b = 3'd0;
        w_next_s = 3'd0;
        if (r_state == ST_BAR) begin
            if (r_bar_s == c_LAST_SEG) begin
                w_next_b = r_bar_b + 3'd1;
            end else begin
                w_next_b = r_bar_b;
                w_next_s = r_bar_s + 3'd1;
            end
        end
        w_bar_stat = (w_next_b <= c_LAST_BAR) ? r_stat[w_next_b] : 3'd0;
    end

    stat_bar_pixel #(
        .BAR_MAX   (BAR_MAX)
    ) u_stat_bar_pixel (
        .i_stat    (w_bar_stat),
        .i_seg     (w_next_s),
        .i_bar_on  (BAR_ON),
        .i_bar_off (BAR_OFF),
        .o_colour  (w_bar_colour)
    );

    // The ROM address is loaded on entry to FETCH so the one-cycle ROM has
    // the word ready for the capture at the end of WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_LATCH;
            r_face_l    <= '0;
            r_stat      <= '0;
            r_pix_idx   <= '0;
            r_bar_b     <= '0;
            r_bar_s     <= '0;
            r_gap_cnt   <= '0;
            r_rom_addr  <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_first <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_LATCH: begin
                    r_face_l   <= w_slot;
                    r_stat     <= {clamp_stat(health_val), clamp_stat(happy_val),
                                   clamp_stat(fun_val), clamp_stat(sleep_val),
                                   clamp_stat(food_val)};
                    r_pix_idx  <= '0;
                    r_rom_addr <= {w_slot, {c_PIX_W{1'b0}}};
                    r_busy     <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_pix_data  <= rom_data;
                    r_pix_valid <= 1'b1;
                    r_pix_first <= (r_pix_idx == '0);
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_pix_first <= 1'b0;
                        if (r_pix_idx == c_LAST_PIX) begin
                            r_pix_data <= w_bar_colour;
                            r_bar_b    <= 3'd0;
                            r_bar_s    <= 3'd0;
                            r_state    <= ST_BAR;
                        end else begin
                            r_pix_valid <= 1'b0;
                            r_pix_idx   <= w_pix_idx_nxt;
                            r_rom_addr  <= {r_face_l, w_pix_idx_nxt};
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                ST_BAR: begin
                    if (w_hs) begin
                        if (w_bar_last) begin
                            r_pix_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_bar_b    <= w_next_b;
                            r_bar_s    <= w_next_s;
                            r_pix_data <= w_bar_colour;
                        end
                    end
                end
                ST_DONE: begin
                    r_gap_cnt <= '0;
                    r_state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= ST_LATCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LATCH;
                end
            endcase
        end
    end

    assign rom_addr      = r_rom_addr;
    assign pix.pix_data  = r_pix_data;
    assign pix.pix_valid = r_pix_valid;
    assign pix.pix_first = r_pix_first;
    assign done          = r_done;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_face_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_face_frame_streamer
// Description : Self-checking bench: frame contents, handshake and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_face_frame_streamer;

    localparam int FRAME_GAP = 20;
    localparam int BEATS     = 281;
    localparam int BUDGET    = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  face = 4'h0;
    logic [2:0]  st [5];
    logic [11:0] rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        done;
    logic        busy;
    bit          bp_en = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    face_frame_streamer_if pix_if ();

    face_frame_streamer #(
        .FRAME_GAP  (FRAME_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .face       (face),
        .food_val   (st[0]),
        .sleep_val  (st[1]),
        .fun_val    (st[2]),
        .happy_val  (st[3]),
        .health_val (st[4]),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix        (pix_if),
        .done       (done),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        return 16'(({4'h0, a} * 16'h9E37) + 16'h1234);
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    initial begin
        pix_if.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_if.pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, a beat is valid && ready there.
    logic [15:0] cap_data [$];
    logic        cap_first[$];
    logic [11:0] cap_addr [$];
    int          cap_cyc  [$];
    int  cyc = 0, done_cnt = 0, done_cyc = 0, first_cyc = 0;
    int  hold_viol = 0, done_wide = 0, busy_viol = 0;
    bit  prev_valid = 0, prev_done = 0, prev_busy = 0, stalled = 0;
    logic [15:0] st_data = '0;
    logic        st_first = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                stalled = 0;
            end else begin
                if (stalled && (!pix_if.pix_valid || pix_if.pix_data !== st_data ||
                                pix_if.pix_first !== st_first))
                    hold_viol++;
                if (pix_if.pix_valid && pix_if.pix_first && !prev_valid)
                    first_cyc = cyc;
                if (pix_if.pix_valid && pix_if.pix_ready) begin
                    cap_data.push_back(pix_if.pix_data);
                    cap_first.push_back(pix_if.pix_first);
                    cap_addr.push_back(rom_addr);
                    cap_cyc.push_back(cyc);
                end
                stalled  = pix_if.pix_valid && !pix_if.pix_ready;
                st_data  = pix_if.pix_data;
                st_first = pix_if.pix_first;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (busy || !prev_busy) busy_viol++;
                    if (prev_done) done_wide++;
                end
            end
            prev_valid = pix_if.pix_valid;
            prev_done  = done;
            prev_busy  = busy;
        end
    end

    logic [15:0] exp_q[$];

    // Reference frame: sprite words in index order, then five 5-segment bars.
    task automatic build_exp(input logic [3:0] f);
        logic [3:0] slot;
        int lit;
        slot = (f == 4'h0 || f >= 4'hD) ? 4'h0 : f;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(rom_word({slot, 8'(i)}));
        for (int b = 0; b < 5; b++) begin
            lit = (int'(st[b]) > 5) ? 5 : int'(st[b]);
            for (int s = 0; s < 5; s++) exp_q.push_back((s < lit) ? 16'h07E0 : 16'h0000);
        end
    endtask

    task automatic clear_capture();
        cap_data.delete(); cap_first.delete(); cap_addr.delete(); cap_cyc.delete();
    endtask

    task automatic wait_done(input string tag);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < BUDGET) begin @(negedge clk); #1; n++; end
        vectors++;
        if (done_cnt == start) begin
            miscompares++;
            $display("FAIL %s_done_timeout: done_cnt %0d, required > %0d", tag, done_cnt, start);
        end
    endtask

    task automatic wait_beats(input string tag, input int nb);
        int n;
        n = 0;
        while (cap_data.size() < nb && n < BUDGET) begin @(negedge clk); #1; n++; end
        vectors++;
        if (cap_data.size() < nb) begin
            miscompares++;
            $display("FAIL %s_beat_timeout: beats %0d, required %0d", tag, cap_data.size(), nb);
        end
    endtask

    task automatic randomize_stats();
        for (int b = 0; b < 5; b++) st[b] = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        face = 4'h8;
        st[0] = 3'd5; st[1] = 3'd3; st[2] = 3'd0; st[3] = 3'd7; st[4] = 3'd1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (pix_if.pix_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", pix_if.pix_valid); end
        vectors++; if (pix_if.pix_first !== 1'b0) begin miscompares++; $display("FAIL rst_first: got %b want 0", pix_if.pix_first); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (rom_addr !== 12'h000) begin miscompares++; $display("FAIL rst_addr: got %h want 000", rom_addr); end
        vectors++; if (pix_if.pix_data !== 16'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0000", pix_if.pix_data); end
        clear_capture();
        rst = 1'b1;
    endtask

    task automatic test_sprite_frame();
        build_exp(4'h8);
        wait_beats("f1", 5);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL f1_busy_mid: got %b want 1", busy); end
        wait_done("f1");
        vectors++;
        if (cap_data.size() != BEATS) begin miscompares++; $display("FAIL f1_beats: got %0d want %0d", cap_data.size(), BEATS); end
        foreach (exp_q[i]) if (i < cap_data.size()) begin
            vectors++;
            if (cap_data[i] !== exp_q[i] || cap_first[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL f1_pix[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_first[i], exp_q[i], i == 0);
            end
        end
        for (int i = 0; i < 256 && i < cap_addr.size(); i++) begin
            vectors++;
            if (cap_addr[i] !== {4'h8, 8'(i)}) begin miscompares++; $display("FAIL f1_addr[%0d]: got %h want %h", i, cap_addr[i], {4'h8, 8'(i)}); end
        end
        if (cap_cyc.size() == BEATS) begin
            // 255 sprite pixels at 3 cycles each, then 25 single-cycle bar beats
            vectors++;
            if (cap_cyc[BEATS-1] - cap_cyc[0] != 255*3 + 25) begin miscompares++; $display("FAIL f1_span: got %0d want %0d", cap_cyc[BEATS-1] - cap_cyc[0], 255*3 + 25); end
            vectors++;
            if (done_cyc - cap_cyc[BEATS-1] != 1) begin miscompares++; $display("FAIL f1_done_lat: got %0d want 1", done_cyc - cap_cyc[BEATS-1]); end
        end
        vectors++; if (done_wide != 0) begin miscompares++; $display("FAIL f1_done_width: got %0d wide pulses want 0", done_wide); end
        vectors++; if (busy_viol != 0) begin miscompares++; $display("FAIL f1_busy_fall: got %0d violations want 0", busy_viol); end
    endtask

    task automatic test_backpressure();
        int t_done;
        t_done = done_cyc;
        randomize_stats();
        face = 4'h8;
        build_exp(4'h8);
        clear_capture();
        bp_en = 1'b1;
        wait_done("bp");
        bp_en = 1'b0;
        // done cycle, FRAME_GAP idle cycles, then LATCH, FETCH, WAIT
        vectors++;
        if (first_cyc - t_done != FRAME_GAP + 4) begin miscompares++; $display("FAIL bp_gap: got %0d want %0d", first_cyc - t_done, FRAME_GAP + 4); end
        vectors++; if (hold_viol != 0) begin miscompares++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_viol); end
        vectors++;
        if (cap_data.size() != BEATS) begin miscompares++; $display("FAIL bp_beats: got %0d want %0d", cap_data.size(), BEATS); end
        foreach (exp_q[i]) if (i < cap_data.size()) begin
            vectors++;
            if (cap_data[i] !== exp_q[i] || cap_first[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL bp_pix[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_first[i], exp_q[i], i == 0);
            end
        end
        vectors++; if (done_wide != 0) begin miscompares++; $display("FAIL bp_done_width: got %0d want 0", done_wide); end
    endtask

    task automatic test_face_change();
        randomize_stats();
        face = 4'h8;
        build_exp(4'h8);
        clear_capture();
        wait_beats("fc", 10);
        face = 4'hA;
        randomize_stats();
        wait_done("fc");
        vectors++;
        if (cap_data.size() != BEATS) begin miscompares++; $display("FAIL fc_beats: got %0d want %0d", cap_data.size(), BEATS); end
        foreach (exp_q[i]) if (i < cap_data.size()) begin
            vectors++;
            if (cap_data[i] !== exp_q[i] || cap_first[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL fc_pix[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_first[i], exp_q[i], i == 0);
            end
        end
        for (int i = 0; i < 256 && i < cap_addr.size(); i++) begin
            vectors++;
            if (cap_addr[i] !== {4'h8, 8'(i)}) begin miscompares++; $display("FAIL fc_addr[%0d]: got %h want %h", i, cap_addr[i], {4'h8, 8'(i)}); end
        end
    endtask

    task automatic test_face_followup();
        build_exp(4'hA);
        clear_capture();
        wait_done("fa");
        vectors++;
        if (cap_data.size() != BEATS) begin miscompares++; $display("FAIL fa_beats: got %0d want %0d", cap_data.size(), BEATS); end
        foreach (exp_q[i]) if (i < cap_data.size()) begin
            vectors++;
            if (cap_data[i] !== exp_q[i] || cap_first[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL fa_pix[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_first[i], exp_q[i], i == 0);
            end
        end
        for (int i = 0; i < 256 && i < cap_addr.size(); i++) begin
            vectors++;
            if (cap_addr[i] !== {4'hA, 8'(i)}) begin miscompares++; $display("FAIL fa_addr[%0d]: got %h want %h", i, cap_addr[i], {4'hA, 8'(i)}); end
        end
    endtask

    task automatic test_blank_face();
        face = 4'hE;
        randomize_stats();
        build_exp(4'hE);
        clear_capture();
        wait_done("bl");
        vectors++;
        if (cap_data.size() != BEATS) begin miscompares++; $display("FAIL bl_beats: got %0d want %0d", cap_data.size(), BEATS); end
        foreach (exp_q[i]) if (i < cap_data.size()) begin
            vectors++;
            if (cap_data[i] !== exp_q[i] || cap_first[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL bl_pix[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_first[i], exp_q[i], i == 0);
            end
        end
        for (int i = 0; i < 256 && i < cap_addr.size(); i++) begin
            vectors++;
            if (cap_addr[i] !== {4'h0, 8'(i)}) begin miscompares++; $display("FAIL bl_addr[%0d]: got %h want %h", i, cap_addr[i], {4'h0, 8'(i)}); end
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        face = 4'h3;
        randomize_stats();
        build_exp(4'h3);
        clear_capture();
        wait_beats("ra", 100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++; if (pix_if.pix_valid !== 1'b0) begin miscompares++; $display("FAIL ra_valid: got %b want 0", pix_if.pix_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ra_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ra_done: got %b want 0", done); end
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        clear_capture();
        rst = 1'b1;
        wait_done("ra");
        vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL ra_done_count: got %0d want %0d", done_cnt - d0, 1); end
        vectors++;
        if (cap_data.size() != BEATS) begin miscompares++; $display("FAIL ra_beats: got %0d want %0d", cap_data.size(), BEATS); end
        foreach (exp_q[i]) if (i < cap_data.size()) begin
            vectors++;
            if (cap_data[i] !== exp_q[i] || cap_first[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL ra_pix[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_first[i], exp_q[i], i == 0);
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 5; b++) st[b] = 3'd0;
        test_reset();
        test_sprite_frame();
        test_backpressure();
        test_face_change();
        test_face_followup();
        test_blank_face();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
